// File: rtl/adc_frame_pkg.sv
`default_nettype none
// ============================================================
// adc_frame_pkg : shared tag, width and state definitions for
//                 the tagged ADC word stream
// Rev 1.0
// ============================================================
package adc_frame_pkg;

    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 16;

    localparam logic [3:0] TAG_START = 4'hE;
    localparam logic [3:0] TAG_A     = 4'h1;
    localparam logic [3:0] TAG_B     = 4'h2;
    localparam logic [3:0] TAG_C     = 4'h3;
    localparam logic [3:0] TAG_D     = 4'h4;
    localparam logic [3:0] TAG_END   = 4'hF;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        H_B  = 3'd1,
        H_C  = 3'd2,
        P_A  = 3'd3,
        P_B  = 3'd4,
        P_C  = 3'd5,
        P_D  = 3'd6
    } adc_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_frame_decoder.sv
`default_nettype none
// ============================================================
// adc_frame_decoder : hunts frame start in the tagged ADC stream
//                     and emits one 4-channel beat per point
// Rev 1.0
// ============================================================
module adc_frame_decoder
    import adc_frame_pkg::*;
#(
    parameter int POINTS_PER_FRAME = 256,
    parameter int PIDX_W           = 14
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*SAMPLE_W-1:0] samp_data,
    output logic                  samp_valid,
    input  logic                  samp_ready,
    output logic                  samp_first,
    output logic                  samp_last,
    output logic [PIDX_W-1:0]     point_idx,
    output logic [7:0]            frame_cnt,
    output logic                  frame_done,
    output logic                  err_tag,
    output logic                  err_len,
    output logic                  err_seq,
    output logic                  locked
);

    localparam logic [PIDX_W-1:0] c_last_idx = PIDX_W'(POINTS_PER_FRAME - 1);

    adc_state_t            r_state;
    logic [SAMPLE_W-1:0]   r_ch_a;
    logic [SAMPLE_W-1:0]   r_ch_b;
    logic [SAMPLE_W-1:0]   r_ch_c;
    logic [PIDX_W-1:0]     r_pidx;
    logic [7:0]            r_prev_cnt;
    logic                  r_first_frame;

    logic                  w_accept;
    logic [3:0]            w_tag;
    logic [SAMPLE_W-1:0]   w_sample;
    logic [7:0]            w_hdr_cnt;
    logic                  w_is_last;
    logic                  w_mismatch;

    // A word may enter whenever the output register is empty or draining this cycle.
    assign in_ready  = !(samp_valid && !samp_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_tag     = in_data[WORD_W-1:SAMPLE_W];
    assign w_sample  = in_data[SAMPLE_W-1:0];
    assign w_hdr_cnt = {frame_cnt[7:4], w_tag};
    assign w_is_last = (r_pidx == c_last_idx);

    always_comb begin
        w_mismatch = 1'b0;
        case (r_state)
            P_A:     w_mismatch = (w_tag != TAG_A);
            P_B:     w_mismatch = (w_tag != TAG_B);
            P_C:     w_mismatch = (w_tag != TAG_C);
            P_D:     w_mismatch = (w_tag != TAG_D) && (w_tag != TAG_END);
            default: w_mismatch = 1'b0;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state       <= HUNT;
            r_ch_a        <= '0;
            r_ch_b        <= '0;
            r_ch_c        <= '0;
            r_pidx        <= '0;
            r_prev_cnt    <= '0;
            r_first_frame <= 1'b1;
            samp_data     <= '0;
            samp_valid    <= 1'b0;
            samp_first    <= 1'b0;
            samp_last     <= 1'b0;
            point_idx     <= '0;
            frame_cnt     <= '0;
            frame_done    <= 1'b0;
            err_tag       <= 1'b0;
            err_len       <= 1'b0;
            err_seq       <= 1'b0;
            locked        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_tag    <= 1'b0;
            err_len    <= 1'b0;
            err_seq    <= 1'b0;
            if (samp_valid && samp_ready) begin
                samp_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_mismatch) begin
                    // Partial point is discarded; a start tag doubles as the next header A.
                    err_tag <= 1'b1;
                    locked  <= 1'b0;
                    if (w_tag == TAG_START) begin
                        r_ch_a  <= w_sample;
                        r_pidx  <= '0;
                        r_state <= H_B;
                    end else begin
                        r_state <= HUNT;
                    end
                end else begin
                    case (r_state)
                        HUNT: begin
                            if (w_tag == TAG_START) begin
                                r_ch_a  <= w_sample;
                                r_pidx  <= '0;
                                r_state <= H_B;
                            end
                        end
                        H_B: begin
                            frame_cnt[7:4] <= w_tag;
                            r_ch_b         <= w_sample;
                            r_state        <= H_C;
                        end
                        H_C: begin
                            frame_cnt[3:0] <= w_tag;
                            r_ch_c         <= w_sample;
                            if (!r_first_frame && (w_hdr_cnt != r_prev_cnt + 8'd1)) begin
                                err_seq <= 1'b1;
                            end
                            r_prev_cnt    <= w_hdr_cnt;
                            r_first_frame <= 1'b0;
                            locked        <= 1'b1;
                            r_state       <= P_D;
                        end
                        P_A: begin
                            r_ch_a  <= w_sample;
                            r_state <= P_B;
                        end
                        P_B: begin
                            r_ch_b  <= w_sample;
                            r_state <= P_C;
                        end
                        P_C: begin
                            r_ch_c  <= w_sample;
                            r_state <= P_D;
                        end
                        P_D: begin
                            samp_valid <= 1'b1;
                            samp_data  <= {w_sample, r_ch_c, r_ch_b, r_ch_a};
                            samp_first <= (r_pidx == '0);
                            samp_last  <= (w_tag == TAG_END);
                            point_idx  <= r_pidx;
                            if (w_tag == TAG_END) begin
                                if (w_is_last) begin
                                    frame_done <= 1'b1;
                                end else begin
                                    err_len <= 1'b1;
                                end
                                locked  <= 1'b0;
                                r_state <= HUNT;
                            end else if (w_is_last) begin
                                err_len <= 1'b1;
                                locked  <= 1'b0;
                                r_state <= HUNT;
                            end else begin
                                r_pidx  <= r_pidx + PIDX_W'(1);
                                r_state <= P_A;
                            end
                        end
                        default: r_state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_decoder.md
Name: adc_frame_decoder

Overview:
- Receive-side decoder for the tagged 16-bit ADC word stream that the ADC capture block writes into the USB ping-pong FIFO.
- Each word carries a 4-bit tag in [15:12] and a 12-bit sample in [11:0].
- The block hunts for frame start, recovers the 8-bit sawtooth frame counter, and reassembles each point's four channel samples into one output beat.
- It checks tag sequence, frame length and counter continuity. It sits after the FIFO read port, for loopback verification and on-FPGA processing.

Parameters:
- POINTS_PER_FRAME, 256, points per sawtooth frame after decimation. Legal range is 2..16383.
- PIDX_W, 14, width of point_idx.

Ports:
- clk_50M  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  16  stream word: tag [15:12], sample [11:0]
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- samp_data  out  48  {chD, chC, chB, chA}, 12 bits each
- samp_valid  out  1  output beat valid
- samp_ready  in  1  downstream accept
- samp_first  out  1  beat is point 0 of its frame
- samp_last  out  1  beat is the end-flagged point
- point_idx  out  PIDX_W  index of the point within its frame
- frame_cnt  out  8  frame counter recovered from the current frame header
- frame_done  out  1  1-cycle pulse when a frame ends correctly
- err_tag  out  1  1-cycle pulse: unexpected tag
- err_len  out  1  1-cycle pulse: end flag early or missing
- err_seq  out  1  1-cycle pulse: frame_cnt is not previous+1 (mod 256)
- locked  out  1  high between a valid header and frame end

Behaviour:
- Clock and reset: one clock, clk_50M. Reset is synchronous and active-high (rst).
- Reset values: all outputs 0, state HUNT, first-frame flag set, in_ready 1.
- Handshake:
  - in_ready = !(samp_valid && !samp_ready).
  - samp_valid rises the cycle after the D word of a point is accepted (1-cycle latency).
  - It holds with stable data until samp_ready is seen.
  - Back-to-back beats are allowed when samp_ready stays high.
- Word processing: the FSM advances only on accepted words.
  - HUNT: drop any word whose tag != 0xE. A tag of 0xE latches chA and goes to H_B.
  - H_B: frame_cnt[7:4] <= tag; latch chB; go to H_C.
  - H_C: frame_cnt[3:0] <= tag; latch chC; go to P_D.
  - P_A: expect tag 0x1. P_B: expect 0x2. P_C: expect 0x3. Each latches its channel.
  - P_D: expect 0x4, or 0xF on the last point. Latch chD, emit the beat, then go to P_A or HUNT.
- Header check (at end of H_C):
  - Not the first frame and frame_cnt != prev+1 mod 256: pulse err_seq. The frame is still decoded.
  - Update prev unconditionally and clear the first-frame flag.
- End-of-frame rules (in P_D):
  - Tag 0xF with point_idx == POINTS_PER_FRAME-1: samp_last=1, pulse frame_done, go to HUNT.
  - Tag 0xF with point_idx < POINTS_PER_FRAME-1: emit the beat with samp_last=1, pulse err_len, go to HUNT.
  - Tag 0x4 with point_idx == POINTS_PER_FRAME-1: emit the beat, pulse err_len, go to HUNT.
- Tag mismatch (P_A/P_B/P_C, or a P_D tag other than 0x4/0xF):
  - Pulse err_tag and discard the partial point; no beat is emitted.
  - If the offending tag is 0xE, resync in the same cycle: treat the word as a header A and go to H_B.
  - Otherwise go to HUNT.
- Counters: point_idx is 0 on the header point and increments per emitted beat. It is reset to 0 on every header, with no wrap.
- Error flags: error pulses are mutually exclusive per word. err_seq and err_len can fire in the same frame.
- Reset mid-frame: any partial point or pending beat is dropped. The first-frame flag is set again, so no err_seq is raised on the next header.

Decomposition:
- Package adc_frame_pkg holds:
  - tag constants: TAG_START=4'hE, TAG_A=1, TAG_B=2, TAG_C=3, TAG_D=4, TAG_END=4'hF;
  - the FSM state enum;
  - SAMPLE_W=12, WORD_W=16.
- The same package is to be shared later by the capture side.
- No sub-module needed. The output holding register is inline.

Test Plan:
- Clean frame, cnt=0x05, POINTS=4, samples 0x100+n: 4 beats. samp_first on beat 0, samp_last on beat 3, frame_done pulse, no errors, frame_cnt=0x05.
- Two frames with cnt 0x05 then 0x07: err_seq pulses once, at the second header. Both frames are fully emitted.
- Garbage words 0x1AAA, 0x4BBB, then a clean frame: the garbage is dropped silently with no err_*, and the frame decodes.
- Point 2 carries word B with tag 0x3: err_tag pulses and point 2 is not emitted. A following 0xE word resyncs, and the next frame decodes.
- Tag 0xF at point 1 with POINTS=4: beat with samp_last=1, err_len pulses, no frame_done.
- samp_ready held low for 10 cycles mid-frame: in_ready drops after the next D word, samp_data stays stable, and no words are lost. Also assert rst mid-frame: all outputs go to 0 and the next frame decodes without err_seq.
